// File: rtl/im_fetch_arbiter.sv
// Round-robin arbiter sharing the single-port instruction memory among the cores.
// It issues one read at a time and strobes the fetched word into the requesting core's IR.
module im_fetch_arbiter #(
  parameter int unsigned NCORES  = 4,
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCORES-1:0]    REQ,
  input  logic [NCORES*AW-1:0] ADDR,
  output logic                 IM_RD,
  output logic [AW-1:0]        IM_ADDR,
  input  logic [DW-1:0]        IM_DATA,
  output logic [NCORES-1:0]    GNT,
  output logic [DW-1:0]        IR_DATA,
  output logic [NCORES-1:0]    IR_WR,
  output logic                 BUSY
);

  localparam int unsigned PW = $clog2(NCORES);

  typedef enum logic [1:0] {StIdle, StRead, StWait, StDeliver} state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                rd_q, rd_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [NCORES-1:0]   gnt_q, gnt_d;
  logic [DW-1:0]       data_q, data_d;
  logic [NCORES-1:0]   wr_q, wr_d;
  logic                busy_q, busy_d;

  logic [AW-1:0]       addr_arr [NCORES];
  logic [PW-1:0]       win;
  logic [PW-1:0]       cand;
  logic                win_vld;

  for (genvar g = 0; g < NCORES; g++) begin : g_addr
    assign addr_arr[g] = ADDR[g*AW +: AW];
  end

  // Scan from the core after the last winner so every requester is served in turn.
  always_comb begin
    win     = ptr_q;
    cand    = ptr_q;
    win_vld = 1'b0;
    for (int unsigned k = 1; k <= NCORES; k++) begin
      cand = PW'((32'(ptr_q) + k) % NCORES);
      if (!win_vld && REQ[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rd_d    = 1'b0;
    addr_d  = addr_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    wr_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d    = StRead;
          ptr_d      = win;
          addr_d     = addr_arr[win];
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          rd_d       = 1'b1;
        end
      end
      StRead: begin
        state_d = StWait;
        cnt_d   = 3'(MEM_LAT);
      end
      StWait: begin
        if (cnt_q == 3'd1) begin
          state_d = StDeliver;
          cnt_d   = '0;
          data_d  = IM_DATA;
          wr_d    = gnt_q;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StDeliver: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= PW'(NCORES - 1);
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      wr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
    end
  end

  assign IM_RD   = rd_q;
  assign IM_ADDR = addr_q;
  assign GNT     = gnt_q;
  assign IR_DATA = data_q;
  assign IR_WR   = wr_q;
  assign BUSY    = busy_q;

  always_ff @(posedge clk) begin
    assert (MEM_LAT >= 1 && MEM_LAT <= 4)
      else $error("im_fetch_arbiter: MEM_LAT %0d outside 1..4", MEM_LAT);
  end

endmodule

// File: doc/im_fetch_arbiter.md
# im_fetch_arbiter

Round-robin arbiter that shares the single-port instruction memory among the cores of the multicore processor. It accepts fetch requests from each core's fetch logic and issues one memory read at a time. It returns the fetched 16-bit word on a shared data bus and pulses a one-hot write strobe into the requesting core's instruction register (the IR's WR/IM inputs). It sits between the per-core IR blocks and the instruction memory.

## Interface
- NCORES, 4: number of requesting cores (2..8).
- AW, 8: instruction memory address width.
- DW, 16: instruction word width; matches the IR width.
- MEM_LAT, 1: memory read latency in cycles from the IM_RD cycle to valid IM_DATA (1..4).

- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- REQ  in  NCORES  per-core fetch request, level-sensitive.
- ADDR  in  NCORES*AW  per-core fetch address; core i occupies bits [i*AW +: AW].
- IM_RD  out  1  memory read strobe, high for exactly one cycle per fetch.
- IM_ADDR  out  AW  memory read address; valid while IM_RD is high.
- IM_DATA  in  DW  memory read data; sampled MEM_LAT cycles after the IM_RD cycle.
- GNT  out  NCORES  one-hot current owner; zero in IDLE.
- IR_DATA  out  DW  fetched word, broadcast to all IRs; holds its value between deliveries.
- IR_WR  out  NCORES  one-hot IR write strobe, high for one cycle per completed fetch.
- BUSY  out  1  high when state is not IDLE.

## Operation
- States: IDLE, READ, WAIT, DELIVER. All outputs are registered.
- IDLE:
  - If REQ is nonzero, select a winner, latch its ADDR, and go to READ.
  - Otherwise stay in IDLE.
- Winner selection: scan indices ptr+1, ptr+2, … modulo NCORES; the first index with REQ high wins.
- ptr:
  - Loads the winner index on the IDLE->READ transition.
  - Resets to NCORES-1, so core 0 has first priority after reset.
- READ:
  - IM_RD=1, IM_ADDR=latched address, GNT=one-hot winner.
  - Load the wait counter with MEM_LAT and go to WAIT.
- WAIT:
  - GNT held, IM_RD=0, counter decrements each cycle.
  - In the cycle the counter reaches 1, capture IM_DATA into IR_DATA and go to DELIVER.
- DELIVER:
  - IR_WR = GNT for one cycle, IR_DATA valid.
  - Next state is IDLE; GNT clears on leaving DELIVER.
- Request semantics:
  - REQ high means "one fetch wanted"; each IR_WR pulse completes one fetch.
  - A REQ still high in the IDLE cycle after delivery counts as a new fetch. ADDR must already hold the next address by then.
  - REQ and ADDR are sampled only in IDLE. Changes during READ/WAIT/DELIVER do not affect the fetch in flight.
  - If REQ drops mid-fetch, the fetch still completes and IR_WR still pulses.
- Reset (asynchronous, any state):
  - State→IDLE, ptr→NCORES-1, counter→0.
  - IM_RD, IM_ADDR, GNT, IR_DATA, IR_WR, BUSY all →0.
  - An in-flight fetch is discarded with no IR_WR; memory data returning after reset is ignored.
- MEM_LAT outside 1..4 is illegal and is flagged by a simulation-only assertion.

## Timing
- Cycle 0: IDLE with REQ sampled high.
- Cycle 1: READ, IM_RD=1.
- Cycles 2..1+MEM_LAT: WAIT; IM_DATA is valid in the last WAIT cycle.
- Cycle 2+MEM_LAT: DELIVER, IR_WR high.
- Cycle 3+MEM_LAT: IDLE, earliest next arbitration.
- Latency from REQ sample to IR_WR: MEM_LAT+2 cycles.
- Sustained throughput: one fetch per MEM_LAT+3 cycles.
- At most one of IR_WR and GNT bits is set; IM_RD is never high on two consecutive cycles.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0, BUSY=0. Release -> first winner among REQ=4'b1111 is core 0.
- Single fetch: MEM_LAT=1, REQ=4'b0100, ADDR[2]=8'h15, memory returns 16'hA5C3.
  - IM_RD=1 with IM_ADDR=8'h15 in cycle 1.
  - IR_WR=4'b0100 and IR_DATA=16'hA5C3 in cycle 3.
  - BUSY low again in cycle 4.
- Fairness: REQ=4'b1111 held, MEM_LAT=1 -> IR_WR sequence cores 0,1,2,3,0, one pulse every 4 cycles, each with its own ADDR.
- Rotation: after core 1 is served, REQ=4'b1010 arrives -> core 3 served first, then core 1.
- Latency and drop: MEM_LAT=3, REQ=4'b0001.
  - IR_WR 5 cycles after the IDLE sample cycle.
  - Dropping REQ during WAIT still yields the IR_WR pulse with the captured data.
- Mid-fetch reset: pulse rst_n low during WAIT -> no IR_WR, all outputs 0. With REQ=4'b1001 afterwards, core 0 wins.
